// File: rtl/button_event_gen_pkg.sv
// Shared types and helpers for the button event generator.
package button_event_gen_pkg;

  // Two-bit per-channel state encoding.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_HOLDING = 2'b10
  } btn_state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width that can hold the largest reload value. Never less than 1 bit.
  function automatic int cnt_width(input int hold_cycles, input int repeat_cycles);
    int w;
    w = $clog2(max_int(hold_cycles, repeat_cycles) + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_event_channel.sv
// Single-channel press / release / hold event FSM with a down-counter timer.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | button released, counter cleared, waiting for a press
//   ST_PRESSED | button down, counting toward the first (long-press) hold
//   ST_HOLDING | long press reached, counting auto-repeat intervals
//                (counter frozen at 0 when auto-repeat is disabled)
module button_event_channel
  import button_event_gen_pkg::*;
#(
  parameter int hold_cycles   = 12500000,
  parameter int repeat_cycles = 2500000,
  parameter int counter_width = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic level_in,
  output logic press_pulse,
  output logic release_pulse,
  output logic hold_pulse,
  output logic held
);

  localparam logic [counter_width-1:0] HOLD_LOAD = counter_width'(hold_cycles - 1);
  localparam bit REPEAT_EN = (repeat_cycles > 0);
  localparam logic [counter_width-1:0] REPEAT_LOAD =
    REPEAT_EN ? counter_width'(repeat_cycles - 1) : '0;

  btn_state_e               state_q, state_d;
  logic [counter_width-1:0] cnt_q, cnt_d;
  logic                     press_q, press_d;
  logic                     release_q, release_d;
  logic                     hold_q, hold_d;
  logic                     held_q, held_d;

  // State, timer and output registers; reset clears everything with no release event.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      hold_q    <= hold_d;
      held_q    <= held_d;
    end
  end

  // Next-state, timer and pulse decode. A release always takes priority over a
  // timer expiry in the same cycle, so at most one pulse is ever produced.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    hold_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (level_in) begin
          state_d = ST_PRESSED;
          cnt_d   = HOLD_LOAD;
          press_d = 1'b1;
        end
      end

      ST_PRESSED: begin
        if (!level_in) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = ST_HOLDING;
          cnt_d   = REPEAT_LOAD;
          hold_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - counter_width'(1);
        end
      end

      ST_HOLDING: begin
        if (!level_in) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (!REPEAT_EN) begin
          cnt_d = '0;
        end else if (cnt_q == '0) begin
          cnt_d  = REPEAT_LOAD;
          hold_d = 1'b1;
        end else begin
          cnt_d = cnt_q - counter_width'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    held_d = (state_d != ST_IDLE);
  end

  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign hold_pulse    = hold_q;
  assign held          = held_q;

endmodule

// File: rtl/button_event_gen.sv
// Multi-channel button event generator: one independent event FSM per channel.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int width         = 1,
  parameter int hold_cycles   = 12500000,
  parameter int repeat_cycles = 2500000,
  parameter int counter_width = cnt_width(hold_cycles, repeat_cycles)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] debounced_signal,
  output logic [width-1:0] press_pulse,
  output logic [width-1:0] release_pulse,
  output logic [width-1:0] hold_pulse,
  output logic [width-1:0] held
);

  // One channel instance per button; channels share nothing but clock and reset.
  for (genvar g = 0; g < width; g++) begin : g_chan
    button_event_channel #(
      .hold_cycles   (hold_cycles),
      .repeat_cycles (repeat_cycles),
      .counter_width (counter_width)
    ) u_chan (
      .clk           (clk),
      .rst           (rst),
      .level_in      (debounced_signal[g]),
      .press_pulse   (press_pulse[g]),
      .release_pulse (release_pulse[g]),
      .hold_pulse    (hold_pulse[g]),
      .held          (held[g])
    );
  end

endmodule

// File: tb/tb_button_event_gen.sv
// Scoreboard bench: stimulus pushes expected pulse events, a negedge monitor
// matches every observed pulse against them and flags missing ones.
module tb_button_event_gen;

  localparam int W    = 2;
  localparam int HOLD = 8;
  localparam int REP  = 4;

  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_HOLD  = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] sig_a = '0, sig_b = '0;
  logic [W-1:0] press_a, rel_a, hold_a, held_a;
  logic [W-1:0] press_b, rel_b, hold_b, held_b;

  int cyc = 0;
  int m_vec = 0, m_err = 0;
  int s_vec = 0, s_err = 0;

  typedef struct {
    int cyc;
    int dut;
    int ch;
    int kind;
  } exp_t;

  exp_t sb[$];

  button_event_gen #(
    .width(W), .hold_cycles(HOLD), .repeat_cycles(REP)
  ) u_dut_a (
    .clk(clk), .rst(rst), .debounced_signal(sig_a),
    .press_pulse(press_a), .release_pulse(rel_a), .hold_pulse(hold_a), .held(held_a)
  );

  button_event_gen #(
    .width(W), .hold_cycles(HOLD), .repeat_cycles(0)
  ) u_dut_b (
    .clk(clk), .rst(rst), .debounced_signal(sig_b),
    .press_pulse(press_b), .release_pulse(rel_b), .hold_pulse(hold_b), .held(held_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every observed pulse must match a pending expectation for this cycle.
  always @(negedge clk) begin
    logic [2:0] bits;
    int idx;
    for (int d = 0; d < 2; d++) begin
      for (int ch = 0; ch < W; ch++) begin
        bits = (d == 0) ? {hold_a[ch], rel_a[ch], press_a[ch]}
                        : {hold_b[ch], rel_b[ch], press_b[ch]};
        for (int k = 0; k < 3; k++) begin
          if (bits[k] !== 1'b0) begin
            m_vec++;
            idx = -1;
            for (int i = 0; i < sb.size(); i++)
              if (idx < 0 && sb[i].cyc == cyc && sb[i].dut == d &&
                  sb[i].ch == ch && sb[i].kind == k)
                idx = i;
            if (idx >= 0) sb.delete(idx);
            else begin
              m_err++;
              $display("FAIL unexpected_pulse: dut%0d ch%0d kind%0d got %b at cycle %0d, expected no pulse",
                       d, ch, k, bits[k], cyc);
            end
          end
        end
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        m_vec++;
        m_err++;
        $display("FAIL missing_pulse: dut%0d ch%0d kind%0d got none, expected at cycle %0d",
                 sb[i].dut, sb[i].ch, sb[i].kind, sb[i].cyc);
        sb.delete(i);
      end
    end
  end

  task automatic exp_ev(input int c, input int d, input int ch, input int kind);
    exp_t e;
    e.cyc = c; e.dut = d; e.ch = ch; e.kind = kind;
    sb.push_back(e);
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    s_vec++;
    if (act !== exp) begin
      s_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    int k, r;
    #2 rst = 1'b0;
    #1;
    chk("reset_press_a", {30'd0, press_a}, 32'd0);
    chk("reset_rel_a",   {30'd0, rel_a},   32'd0);
    chk("reset_hold_a",  {30'd0, hold_a},  32'd0);
    chk("reset_held_a",  {30'd0, held_a},  32'd0);
    chk("reset_held_b",  {30'd0, held_b},  32'd0);
    step(3);
    rst = 1'b1;
    step(3);

    // Channel 0 held for 20 cycles: holds at 9, 13, 17; the 21 expiry loses to release.
    k = cyc;
    sig_a[0] = 1'b1;
    exp_ev(k + 1, 0, 0, K_PRESS);
    exp_ev(k + 9, 0, 0, K_HOLD);
    exp_ev(k + 13, 0, 0, K_HOLD);
    exp_ev(k + 17, 0, 0, K_HOLD);
    exp_ev(k + 21, 0, 0, K_REL);
    step(5);
    chk("held_mid_press", {30'd0, held_a}, 32'd1);
    step(15);
    sig_a[0] = 1'b0;
    step(6);
    chk("held_after_release", {30'd0, held_a}, 32'd0);

    // Exactly hold_cycles high: expiry and release collide, release wins.
    k = cyc;
    sig_a[0] = 1'b1;
    exp_ev(k + 1, 0, 0, K_PRESS);
    exp_ev(k + 9, 0, 0, K_REL);
    step(8);
    sig_a[0] = 1'b0;
    step(4);

    // Single-cycle press: press and release on adjacent cycles.
    k = cyc;
    sig_a[1] = 1'b1;
    exp_ev(k + 1, 0, 1, K_PRESS);
    exp_ev(k + 2, 0, 1, K_REL);
    step(1);
    sig_a[1] = 1'b0;
    chk("held_one_cycle_hi", {30'd0, held_a}, 32'd2);
    step(1);
    chk("held_one_cycle_lo", {30'd0, held_a}, 32'd0);
    step(3);

    // Reset mid-hold: asynchronous clear, no release; re-press after deassertion.
    k = cyc;
    sig_a[0] = 1'b1;
    exp_ev(k + 1, 0, 0, K_PRESS);
    exp_ev(k + 9, 0, 0, K_HOLD);
    step(10);
    chk("held_before_reset", {30'd0, held_a}, 32'd1);
    rst = 1'b0;
    #1;
    chk("async_reset_held",  {30'd0, held_a},  32'd0);
    chk("async_reset_pulse", {29'd0, press_a[0], rel_a[0], hold_a[0]}, 32'd0);
    step(2);
    r = cyc;
    #1 rst = 1'b1;
    exp_ev(r + 1, 0, 0, K_PRESS);
    exp_ev(r + 4, 0, 0, K_REL);
    step(3);
    sig_a[0] = 1'b0;
    step(4);

    // Two channels pressed 3 cycles apart, each held 14 cycles.
    k = cyc;
    sig_a[0] = 1'b1;
    exp_ev(k + 1, 0, 0, K_PRESS);
    exp_ev(k + 9, 0, 0, K_HOLD);
    exp_ev(k + 13, 0, 0, K_HOLD);
    exp_ev(k + 15, 0, 0, K_REL);
    exp_ev(k + 4, 0, 1, K_PRESS);
    exp_ev(k + 12, 0, 1, K_HOLD);
    exp_ev(k + 16, 0, 1, K_HOLD);
    exp_ev(k + 18, 0, 1, K_REL);
    step(3);
    sig_a[1] = 1'b1;
    step(11);
    sig_a[0] = 1'b0;
    step(3);
    sig_a[1] = 1'b0;
    step(4);

    // No auto-repeat: a single hold at 9 then silence; ch1 collides at expiry.
    k = cyc;
    sig_b = 2'b11;
    exp_ev(k + 1, 1, 0, K_PRESS);
    exp_ev(k + 9, 1, 0, K_HOLD);
    exp_ev(k + 21, 1, 0, K_REL);
    exp_ev(k + 1, 1, 1, K_PRESS);
    exp_ev(k + 9, 1, 1, K_REL);
    step(8);
    sig_b[1] = 1'b0;
    step(4);
    chk("held_no_repeat", {30'd0, held_b}, 32'd1);
    step(8);
    sig_b[0] = 1'b0;
    step(4);
    chk("held_no_repeat_end", {30'd0, held_b}, 32'd0);

    step(3);
    $display("== %0d vectors applied, %0d miscompares ==", m_vec + s_vec, m_err + s_err);
    $finish;
  end

endmodule

// File: doc/button_event_gen.md
BUTTON_EVENT_GEN -- requirements
Module: button_event_gen

Interface
REQ-001 Parameter width, default 1: number of independent button channels.
REQ-002 Parameter hold_cycles, default 12500000: held cycles after the press pulse before the first hold pulse; legal range >= 2.
REQ-003 Parameter repeat_cycles, default 2500000: cycles between successive hold pulses; 0 means a single hold pulse only.
REQ-004 Parameter counter_width, default `log2(max(hold_cycles, repeat_cycles)+1)`: per-channel counter width.
REQ-005 clk  input  1  single system clock; all state updates on rising edge.
REQ-006 rst  input  1  asynchronous reset, active-low; named rst as in the rest of the codebase, with polarity fixed low.
REQ-007 debounced_signal  input  width  clean level per channel, driven by the debouncer, already synchronous to clk.
REQ-008 press_pulse  output  width  one-cycle pulse per channel on press.
REQ-009 release_pulse  output  width  one-cycle pulse per channel on release.
REQ-010 hold_pulse  output  width  one-cycle pulse per channel on long-press and on each auto-repeat.
REQ-011 held  output  width  level, high while the channel FSM is in PRESSED or HOLDING.

Function
REQ-012 Each channel SHALL run an independent FSM with states IDLE, PRESSED and HOLDING, and a counter_width-bit down-counter.
REQ-013 IDLE with input 1 at edge N SHALL move to PRESSED, load the counter with hold_cycles-1, and assert press_pulse during cycle N+1 only. Latency is 1 cycle.
REQ-014 In PRESSED with input 1, the counter SHALL decrement each edge. When it is 0 at an edge, the FSM SHALL assert hold_pulse for the following cycle. The first hold_pulse SHALL therefore occur exactly hold_cycles cycles after press_pulse.
REQ-015 On that same edge, PRESSED SHALL go to HOLDING and load repeat_cycles-1. If repeat_cycles=0, it SHALL go to HOLDING with the counter frozen and issue no further hold pulses.
REQ-016 In HOLDING with input 1, the counter SHALL decrement. At 0 it SHALL pulse hold_pulse and reload repeat_cycles-1. Successive hold pulses SHALL be exactly repeat_cycles apart.
REQ-017 Input 0 at an edge in PRESSED or HOLDING SHALL move to IDLE, clear the counter, and assert release_pulse for the next cycle only.
REQ-018 Simultaneous release and counter expiry: release wins. release_pulse SHALL fire and hold_pulse SHALL stay 0.
REQ-019 At most one of press_pulse, release_pulse and hold_pulse SHALL be high per channel per cycle.
REQ-020 Input 0 in IDLE SHALL produce no pulse.
REQ-021 A 1-cycle input high SHALL produce press_pulse followed by release_pulse on consecutive cycles.
REQ-022 All outputs SHALL be registered, with no combinational path from debounced_signal to any output.
REQ-023 held SHALL rise in the same cycle as press_pulse and fall in the same cycle as release_pulse.
REQ-024 Counter arithmetic SHALL never wrap below 0; the counter is reloaded or frozen at 0.

Reset
REQ-025 While rst=0, all FSMs SHALL be IDLE, all counters 0, and press_pulse, release_pulse, hold_pulse and held all 0, asynchronously.
REQ-026 Reset asserted mid-press SHALL clear immediately and emit no release_pulse.
REQ-027 If input is 1 at reset deassertion, press_pulse SHALL fire one cycle after the first post-reset edge.
REQ-028 Reset deassertion is assumed synchronized externally by the top level; the block performs no internal reset synchronization.

Structure
REQ-029 The `log2` macro SHALL come from the shared util.vh header. The FSM state encodings SHALL be localparams in a shared include, button_event_defs.vh.
REQ-030 One sub-module, button_event_channel (single-bit FSM, counter and output registers), SHALL be instantiated width times via a generate loop.
REQ-031 Synthesis SHALL infer one counter_width-bit counter and two state bits per channel; no memories.

Verification (width=2, hold_cycles=8, repeat_cycles=4)
REQ-032 Press channel 0 for 20 cycles -> press_pulse[0] at cycle 1, hold_pulse[0] at cycles 9, 13 and 17, release_pulse[0] at cycle 21; channel 1 all 0.
REQ-033 Hold input high for exactly 8 cycles -> press_pulse, then release_pulse with no hold_pulse (the release-wins collision case).
REQ-034 A 1-cycle input high -> press_pulse and release_pulse on adjacent cycles; held high 1 cycle.
REQ-035 Assert rst=0 at cycle 10 of a hold -> all outputs 0 within the same cycle, no release_pulse. Deassert with input still high -> press_pulse one cycle after the first post-reset edge.
REQ-036 Channels 0 and 1 pressed with a 3-cycle offset -> independent, correctly offset pulse trains. With repeat_cycles=0 -> exactly one hold_pulse at cycle 9, then none until release.
